pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that replaces the fixed-field, reset-only inter-stage latches of the 6-stage CPU with a single generic block. It carries an opaque payload, for example the packed EX/M bundle of PC+1, WB, Mem, ALU, store data, zero-pad and dest, which is 72 bits. Ready/valid backpressure, flush (branch/exception kill) and a stall performance counter are built in. It sits between any two pipeline stages; the hazard unit drives `flush`, and the downstream stage drives `out_ready`.

---
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic pipeline stage register with ready/valid handshake,
//               flush, and a saturating stall counter. Define
//               PIPE_STAGE_SKID_EN to add a skid entry (two-deep,
//               registered in_ready).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 72,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_count,
  input  logic                 stall_count_clr
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] S_FULL  = 2'd2;
`endif
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [PAYLOAD_W-1:0] r_main;
  logic [CNT_W-1:0]     r_stall_count;
  logic                 w_accept;
  logic                 w_emit;
  logic                 w_load_main_in;
`ifdef PIPE_STAGE_SKID_EN
  logic [PAYLOAD_W-1:0] r_skid;
  logic                 w_load_main_skid;
  logic                 w_load_skid;
`endif

  assign w_accept = in_valid & in_ready;
  assign w_emit   = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus payload load strobes; flush suppresses every load.
  always_comb begin
    w_next_state   = r_state;
    w_load_main_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
`endif
    if (flush) begin
      w_next_state = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          w_load_main_in = w_accept;
          if (w_accept) begin
            w_next_state = S_BUSY;
          end
        end
        S_BUSY: begin
          w_load_main_in = w_accept & w_emit;
          if (w_emit && !w_accept) begin
            w_next_state = S_EMPTY;
          end
`ifdef PIPE_STAGE_SKID_EN
          w_load_skid = w_accept & ~w_emit;
          if (w_accept && !w_emit) begin
            w_next_state = S_FULL;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        S_FULL: begin
          w_load_main_skid = w_emit;
          if (w_emit) begin
            w_next_state = S_BUSY;
          end
        end
`endif
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (r_state != S_EMPTY);
    occupancy = r_state;
`ifdef PIPE_STAGE_SKID_EN
    in_ready  = (r_state != S_FULL);
`else
    // Single entry: a held beat can be replaced only while it is leaving.
    in_ready  = out_ready | (r_state == S_EMPTY);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_main <= '0;
    end else if (w_load_main_in) begin
      r_main <= in_payload;
`ifdef PIPE_STAGE_SKID_EN
    end else if (w_load_main_skid) begin
      r_main <= r_skid;
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_skid <= '0;
    end else if (w_load_skid) begin
      r_skid <= in_payload;
    end
  end
`endif

  // Saturating stall counter; clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (stall_count_clr) begin
      r_stall_count <= '0;
    end else if (out_valid && !out_ready && (r_stall_count != C_CNT_MAX)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign out_payload = r_main;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Testbench for pipe_stage_reg: directed vector table plus hand sequences for
// flush, counter saturation/clear and asynchronous reset.
module tb_pipe_stage_reg;
  localparam int PW = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_payload = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_payload;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_count;
  logic          stall_count_clr = 1'b0;

  pipe_stage_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_payload      (in_payload),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_payload     (out_payload),
    .occupancy       (occupancy),
    .stall_count     (stall_count),
    .stall_count_clr (stall_count_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       vi;
    logic [7:0] pl;
    logic       ordy;
    logic       fl;
    logic       ir;   // in_ready before the edge
    logic       ov;   // outputs after the edge
    logic [7:0] opl;
    logic [1:0] occ;
    logic [3:0] sc;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] OCC_HELD  = 2'd2;
  localparam logic [3:0] SC_FLUSH  = 4'd5;
`else
  localparam logic [1:0] OCC_HELD  = 2'd1;
  localparam logic [3:0] SC_FLUSH  = 4'd4;
`endif

  task automatic add(input logic vi, input logic [7:0] pl, input logic ordy,
                     input logic fl, input logic ir, input logic ov,
                     input logic [7:0] opl, input logic [1:0] occ,
                     input logic [3:0] sc);
    vec_t v;
    v.vi = vi; v.pl = pl; v.ordy = ordy; v.fl = fl; v.ir = ir;
    v.ov = ov; v.opl = opl; v.occ = occ; v.sc = sc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic vi, input logic [7:0] pl, input logic ordy,
                       input logic fl, input logic clr);
    in_valid = vi; in_payload = pl; out_ready = ordy;
    flush = fl; stall_count_clr = clr;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    n_vec++;
  endtask

  task automatic step(input logic vi, input logic [7:0] pl, input logic ordy,
                      input logic fl, input logic clr);
    drive(vi, pl, ordy, fl, clr);
    tick();
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [7:0] opl,
                         input logic [1:0] occ, input logic [3:0] sc);
    chk({tag, ".out_valid"}, n_vec, out_valid, ov);
    chk({tag, ".out_payload"}, n_vec, out_payload, opl);
    chk({tag, ".occupancy"}, n_vec, occupancy, occ);
    chk({tag, ".stall_count"}, n_vec, stall_count, sc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming: one beat per cycle, visible one cycle after acceptance.
    for (int k = 1; k <= 8; k++) begin
      add(1'b1, 8'(k), 1'b1, 1'b0, 1'b1, 1'b1, 8'(k), 2'd1, 4'd0);
    end
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h08, 2'd0, 4'd0);
    // Backpressure: A accepted, three stalled cycles, then drain in order.
`ifdef PIPE_STAGE_SKID_EN
    add(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1, 4'd0);
    add(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd2, 4'd1);
    add(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2, 4'd2);
    add(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2, 4'd3);
    add(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2, 2'd1, 4'd3);
    add(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 2'd1, 4'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 2'd0, 4'd3);
`else
    add(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1, 4'd0);
    add(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 4'd1);
    add(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 4'd2);
    add(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 4'd3);
    add(1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 2'd1, 4'd3);
    add(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 2'd1, 4'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 2'd0, 4'd3);
`endif

    // Reset state.
    @(negedge clock);
    chk("reset.in_ready", n_vec, in_ready, 1'b1);
    chk_out("reset", 1'b0, 8'h00, 2'd0, 4'd0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].vi, tbl[i].pl, tbl[i].ordy, tbl[i].fl, 1'b0);
      #1;
      chk("tbl.in_ready", i, in_ready, tbl[i].ir);
      tick();
      chk_out("tbl", tbl[i].ov, tbl[i].opl, tbl[i].occ, tbl[i].sc);
    end

    // Flush while holding: valids clear, payload stays stale, counter unaffected.
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    chk("full.occupancy", n_vec, occupancy, 2'd2);
    drive(1'b1, 8'hD4, 1'b1, 1'b0, 1'b0);
    #1;
    chk("full.in_ready_indep", n_vec, in_ready, 1'b0);
`else
    drive(1'b1, 8'hD4, 1'b0, 1'b0, 1'b0);
    #1;
    chk("busy.in_ready_lo", n_vec, in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("busy.in_ready_follows", n_vec, in_ready, 1'b1);
`endif
    drive(1'b1, 8'hD4, 1'b0, 1'b1, 1'b0);
    #1;
    tick();
    chk_out("flush", 1'b0, 8'hA1, 2'd0, SC_FLUSH);
    step(1'b1, 8'hE5, 1'b1, 1'b0, 1'b0);
    chk_out("post_flush", 1'b1, 8'hE5, 2'd1, SC_FLUSH);

    // Counter clear during a stall, then saturation.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr.stall_count", n_vec, stall_count, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (k == 14) chk("sat14.stall_count", n_vec, stall_count, 4'd14);
    end
    chk_out("sat", 1'b1, 8'hE5, 2'd1, 4'd15);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr2.stall_count", n_vec, stall_count, 4'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("after_clr.stall_count", n_vec, stall_count, 4'd1);

    // Asynchronous reset while holding beats.
    step(1'b1, 8'hF6, 1'b0, 1'b0, 1'b0);
    chk("pre_rst.occupancy", n_vec, occupancy, OCC_HELD);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.in_ready", n_vec, in_ready, 1'b1);
    chk_out("arst", 1'b0, 8'h00, 2'd0, 4'd0);
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk_out("post_rst", 1'b1, 8'h77, 2'd1, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
